// File: rtl/eq_mon_pkg.sv
// Shared definitions for the equality match monitor.
//   state_t : 2-bit FSM encoding (IDLE / SEARCH / LOCKED)
//   sat_inc : saturating increment of a counter of a given bit width
package eq_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Increment val, but never past the all-ones value of a width-bit counter.
  // Callers zero-extend their counter to 32 bits and size-cast the result back.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/eq_match_monitor_if.sv
// Bus bundle for eq_match_monitor.
//   Inputs to the monitor : clr, in_valid, a, b
//   Outputs from monitor  : aeqb_q, out_valid, run_len, match_total,
//                           sample_total, locked, lost, dbg_state
// Handshake: there is no backpressure. Every cycle with in_valid=1 and clr=0
// is an accepted sample; out_valid pulses for exactly one cycle one clock
// later with aeqb_q and the counters already updated. clr wins over in_valid.
interface eq_match_monitor_if #(
  parameter int W     = 2,
  parameter int CNT_W = 8
) ();
  import eq_mon_pkg::*;

  logic             clr;
  logic             in_valid;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             aeqb_q;
  logic             out_valid;
  logic [CNT_W-1:0] run_len;
  logic [CNT_W-1:0] match_total;
  logic [CNT_W-1:0] sample_total;
  logic             locked;
  logic             lost;
  state_t           dbg_state;

  modport master (
    output clr, in_valid, a, b,
    input  aeqb_q, out_valid, run_len, match_total, sample_total, locked, lost, dbg_state
  );

  modport slave (
    input  clr, in_valid, a, b,
    output aeqb_q, out_valid, run_len, match_total, sample_total, locked, lost, dbg_state
  );
endinterface

// File: rtl/eq_match_monitor_cmp.sv
// Pure combinational W-bit equality comparator.
//   i_a, i_b : operands
//   o_aeqb   : 1 when i_a == i_b
module eq_cmp #(
  parameter int W = 2
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_aeqb
);
  assign o_aeqb = (i_a == i_b);
endmodule

// File: rtl/eq_match_monitor.sv
// Registered match monitor: compares accepted a/b samples, counts samples,
// matches and the current run of consecutive matches (all saturating), and
// declares lock after LOCK_CNT consecutive matches.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : eq_match_monitor_if slave (see interface for signal list)
module eq_match_monitor
  import eq_mon_pkg::*;
#(
  parameter int W        = 2,
  parameter int LOCK_CNT = 4,
  parameter int CNT_W    = 8
) (
  input logic               clk,
  input logic               reset_n,
  eq_match_monitor_if.slave bus
);

  localparam logic [31:0] LOCK_U = LOCK_CNT;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_eq;
  logic             w_accept;
  logic             w_lock_hit;
  logic             w_lost_nxt;
  logic [CNT_W-1:0] w_run_inc;
  logic [CNT_W-1:0] w_match_inc;
  logic [CNT_W-1:0] w_sample_inc;
  logic [CNT_W-1:0] r_run;
  logic [CNT_W-1:0] r_match;
  logic [CNT_W-1:0] r_sample;
  logic             r_aeqb;
  logic             r_out_valid;
  logic             r_lost;

  eq_cmp #(.W(W)) u_cmp (
    .i_a    (bus.a),
    .i_b    (bus.b),
    .o_aeqb (w_eq)
  );

  assign w_accept     = bus.in_valid & ~bus.clr;
  assign w_run_inc    = CNT_W'(sat_inc(32'(r_run), CNT_W));
  assign w_match_inc  = CNT_W'(sat_inc(32'(r_match), CNT_W));
  assign w_sample_inc = CNT_W'(sat_inc(32'(r_sample), CNT_W));

  // ">=" rather than "==" so a saturated run still qualifies for lock.
  assign w_lock_hit = w_eq && (32'(w_run_inc) >= LOCK_U);

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM next-state and loss detection
  always_comb begin
    w_state_nxt = r_state;
    w_lost_nxt  = 1'b0;
    if (bus.clr) begin
      w_state_nxt = ST_IDLE;
    end else if (w_accept) begin
      case (r_state)
        ST_IDLE, ST_SEARCH: w_state_nxt = w_lock_hit ? ST_LOCKED : ST_SEARCH;
        ST_LOCKED: begin
          if (!w_eq) begin
            w_state_nxt = ST_SEARCH;
            w_lost_nxt  = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Result and statistics registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_aeqb      <= 1'b0;
      r_out_valid <= 1'b0;
      r_lost      <= 1'b0;
      r_run       <= '0;
      r_match     <= '0;
      r_sample    <= '0;
    end else if (bus.clr) begin
      r_aeqb      <= 1'b0;
      r_out_valid <= 1'b0;
      r_lost      <= 1'b0;
      r_run       <= '0;
      r_match     <= '0;
      r_sample    <= '0;
    end else begin
      r_out_valid <= w_accept;
      r_lost      <= w_lost_nxt;
      if (w_accept) begin
        r_aeqb   <= w_eq;
        r_sample <= w_sample_inc;
        if (w_eq) begin
          r_match <= w_match_inc;
          r_run   <= w_run_inc;
        end else begin
          r_run   <= '0;
        end
      end
    end
  end

  assign bus.aeqb_q       = r_aeqb;
  assign bus.out_valid    = r_out_valid;
  assign bus.run_len      = r_run;
  assign bus.match_total  = r_match;
  assign bus.sample_total = r_sample;
  assign bus.locked       = (r_state == ST_LOCKED);
  assign bus.lost         = r_lost;
  assign bus.dbg_state    = r_state;

endmodule

// File: tb/tb_eq_match_monitor.sv
// Bench for eq_match_monitor: one instance with CNT_W=8 and one with CNT_W=3
// (saturation). Drivers push hand-computed expected result words into a
// queue per instance; a negedge monitor per instance pops and compares on
// each out_valid, and on other cycles checks that outputs hold with lost=0.
// Result word layout: {aeqb_q, run_len, match_total, sample_total, locked, lost}
module tb_eq_match_monitor;
  import eq_mon_pkg::*;

  localparam int W     = 2;
  localparam int CW    = 8;
  localparam int CW3   = 3;
  localparam int EXP_W = 1 + 3 * CW + 2;

  // ---------------- clock / reset ----------------
  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [EXP_W-1:0] exp_q8[$];
  logic [EXP_W-1:0] exp_q3[$];
  logic [EXP_W-1:0] last8 = '0;
  logic [EXP_W-1:0] last3 = '0;
  logic [EXP_W-1:0] e8;
  logic [EXP_W-1:0] e3;
  logic [EXP_W-1:0] got8;
  logic [EXP_W-1:0] got3;

  eq_match_monitor_if #(.W(W), .CNT_W(CW))  bus8 ();
  eq_match_monitor_if #(.W(W), .CNT_W(CW3)) bus3 ();

  eq_match_monitor #(.W(W), .LOCK_CNT(4), .CNT_W(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus8)
  );

  eq_match_monitor #(.W(W), .LOCK_CNT(4), .CNT_W(CW3)) dut3 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus3)
  );

  assign got8 = {bus8.aeqb_q, bus8.run_len, bus8.match_total, bus8.sample_total,
                 bus8.locked, bus8.lost};
  assign got3 = {bus3.aeqb_q, CW'(bus3.run_len), CW'(bus3.match_total),
                 CW'(bus3.sample_total), bus3.locked, bus3.lost};

  function automatic logic [EXP_W-1:0] pack(input logic eq, input int run, input int m,
                                            input int s, input logic lk, input logic lo);
    return {eq, CW'(run), CW'(m), CW'(s), lk, lo};
  endfunction

  task automatic check(input string nm, input logic [EXP_W-1:0] got,
                       input logic [EXP_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus8.out_valid) begin
        if (exp_q8.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL dut8_unexpected_out_valid: got out_valid=1 expected 0 (t=%0t)", $time);
        end else begin
          e8 = exp_q8.pop_front();
          check("dut8_result", got8, e8);
          last8 = e8;
        end
      end else begin
        check("dut8_hold", got8, {last8[EXP_W-1:1], 1'b0});
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus3.out_valid) begin
        if (exp_q3.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL dut3_unexpected_out_valid: got out_valid=1 expected 0 (t=%0t)", $time);
        end else begin
          e3 = exp_q3.pop_front();
          check("dut3_result", got3, e3);
          last3 = e3;
        end
      end else begin
        check("dut3_hold", got3, {last3[EXP_W-1:1], 1'b0});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send8(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [EXP_W-1:0] exp);
    @(posedge clk); #1;
    bus8.in_valid = 1'b1;
    bus8.a        = a;
    bus8.b        = b;
    exp_q8.push_back(exp);
  endtask

  task automatic send3(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [EXP_W-1:0] exp);
    @(posedge clk); #1;
    bus3.in_valid = 1'b1;
    bus3.a        = a;
    bus3.b        = b;
    exp_q3.push_back(exp);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    bus3.in_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus8.clr = 1'b0; bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0;
    bus3.clr = 1'b0; bus3.in_valid = 1'b0; bus3.a = '0; bus3.b = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_out8",   got8, '0);
    check("reset_out3",   got3, '0);
    check("reset_ovld8",  EXP_W'(bus8.out_valid), '0);
    check("reset_state8", EXP_W'(bus8.dbg_state), EXP_W'(ST_IDLE));
    reset_n = 1'b1;

    // 1: mixed pairs
    send8(2'b00, 2'b00, pack(1, 1, 1, 1, 0, 0));
    send8(2'b01, 2'b00, pack(0, 0, 1, 2, 0, 0));
    send8(2'b01, 2'b11, pack(0, 0, 1, 3, 0, 0));
    send8(2'b10, 2'b10, pack(1, 1, 2, 4, 0, 0));
    send8(2'b10, 2'b00, pack(0, 0, 2, 5, 0, 0));
    send8(2'b11, 2'b11, pack(1, 1, 3, 6, 0, 0));
    send8(2'b11, 2'b01, pack(0, 0, 3, 7, 0, 0));

    // 2: four back-to-back matches -> lock on the fourth
    send8(2'b10, 2'b10, pack(1, 1, 4, 8, 0, 0));
    send8(2'b10, 2'b10, pack(1, 2, 5, 9, 0, 0));
    send8(2'b10, 2'b10, pack(1, 3, 6, 10, 0, 0));
    send8(2'b10, 2'b10, pack(1, 4, 7, 11, 1, 0));

    // 3: mismatch while locked -> lost pulse, back to SEARCH
    send8(2'b11, 2'b01, pack(0, 0, 7, 12, 0, 1));
    idle();
    check("state_after_loss", EXP_W'(bus8.dbg_state), EXP_W'(ST_SEARCH));

    // 4: matches separated by idle cycles
    send8(2'b01, 2'b01, pack(1, 1, 8, 13, 0, 0));
    idle();
    send8(2'b01, 2'b01, pack(1, 2, 9, 14, 0, 0));
    idle();
    send8(2'b01, 2'b01, pack(1, 3, 10, 15, 0, 0));
    idle();
    send8(2'b01, 2'b01, pack(1, 4, 11, 16, 1, 0));
    idle();
    check("state_after_gap_lock", EXP_W'(bus8.dbg_state), EXP_W'(ST_LOCKED));

    // 5: CNT_W=3 instance saturates at 7 and stays locked
    send3(2'b01, 2'b01, pack(1, 1, 1, 1, 0, 0));
    send3(2'b01, 2'b01, pack(1, 2, 2, 2, 0, 0));
    send3(2'b01, 2'b01, pack(1, 3, 3, 3, 0, 0));
    send3(2'b01, 2'b01, pack(1, 4, 4, 4, 1, 0));
    send3(2'b01, 2'b01, pack(1, 5, 5, 5, 1, 0));
    send3(2'b01, 2'b01, pack(1, 6, 6, 6, 1, 0));
    send3(2'b01, 2'b01, pack(1, 7, 7, 7, 1, 0));
    send3(2'b01, 2'b01, pack(1, 7, 7, 7, 1, 0));
    send3(2'b01, 2'b01, pack(1, 7, 7, 7, 1, 0));
    idle();

    // 6a: clr together with a mismatching sample while locked
    @(posedge clk); #1;
    bus8.clr = 1'b1; bus8.in_valid = 1'b1; bus8.a = 2'b11; bus8.b = 2'b01;
    @(posedge clk); #1;
    bus8.clr = 1'b0; bus8.in_valid = 1'b0;
    last8 = '0;
    check("clr_out8",   got8, '0);
    check("clr_ovld8",  EXP_W'(bus8.out_valid), '0);
    check("clr_state8", EXP_W'(bus8.dbg_state), EXP_W'(ST_IDLE));

    // 6b: fresh run after clr, then asynchronous reset mid-sequence
    send8(2'b10, 2'b10, pack(1, 1, 1, 1, 0, 0));
    send8(2'b00, 2'b00, pack(1, 2, 2, 2, 0, 0));
    idle();
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check("arst_out8",   got8, '0);
    check("arst_out3",   got3, '0);
    check("arst_state8", EXP_W'(bus8.dbg_state), EXP_W'(ST_IDLE));
    check("arst_state3", EXP_W'(bus3.dbg_state), EXP_W'(ST_IDLE));
    last8 = '0;
    last3 = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    send8(2'b10, 2'b10, pack(1, 1, 1, 1, 0, 0));
    idle();

    repeat (3) @(posedge clk);
    #1;
    check("q8_drained", EXP_W'(exp_q8.size()), '0);
    check("q3_drained", EXP_W'(exp_q3.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

endmodule
